// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: TLB maintenance op sequencer; define TLBFILL_RANDOM_EN to pick the TLBFILL index from an LFSR
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int TLBNUMSIZE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [2:0]            op_type,
  input  logic [4:0]            inv_op,
  input  logic [9:0]            inv_asid,
  input  logic [18:0]           inv_va,
  input  logic [TLBNUMSIZE-1:0] csr_index,
  input  logic [9:0]            csr_asid,
  input  logic [18:0]           csr_vppn,
  output logic                  s_req,
  output logic [18:0]           s_vppn,
  output logic [9:0]            s_asid,
  input  logic                  s_found,
  input  logic [TLBNUMSIZE-1:0] s_index,
  output logic                  s1e,
  output logic [TLBNUMSIZE-1:0] s1_index,
  output logic                  s1_ne,
  output logic                  re,
  output logic [TLBNUMSIZE-1:0] r_index,
  output logic                  we,
  output logic [TLBNUMSIZE-1:0] w_index,
  output logic [TLBNUMSIZE-1:0] scan_index,
  input  logic                  scan_e,
  input  logic                  scan_g,
  input  logic [5:0]            scan_ps,
  input  logic [9:0]            scan_asid,
  input  logic [18:0]           scan_vppn,
  output logic                  inv_we,
  output logic [TLBNUMSIZE-1:0] inv_index,
  output logic                  done,
  output logic                  refetch,
  output logic                  ine_exc
);
  typedef enum logic [2:0] {IDLE, SRCH_REQ, SRCH_RSP, RD, WR, INV_SCAN} state_t;
  state_t state_q, state_d;
  logic ine_q, ine_d, fill_q, fill_d;
  logic [4:0] iop_q, iop_d;
  logic [9:0] asid_q, asid_d;
  logic [18:0] va_q, va_d;
  logic [TLBNUMSIZE-1:0] idx_q, idx_d, cnt_q, cnt_d, fill_idx;
  logic accept, bad, is_inv, scanning, last, asid_eq, va_hit, match;
  assign accept = op_valid & op_ready;
  assign is_inv = op_type == 3'd4;
  assign bad = (op_type > 3'd4) | (is_inv & (inv_op > 5'd6));
  assign scanning = state_q == INV_SCAN;
  assign last = cnt_q == TLBNUMSIZE'(TLBNUM - 1);
  assign asid_eq = scan_asid == asid_q;
  assign va_hit = (scan_ps == 6'd21) ? (scan_vppn[18:9] == va_q[18:9]) : (scan_vppn == va_q);
  assign match = (iop_q < 5'd2) ? 1'b1 :
                 (iop_q == 5'd2) ? scan_g :
                 (iop_q == 5'd3) ? ~scan_g :
                 (iop_q == 5'd4) ? ~scan_g & asid_eq :
                 (iop_q == 5'd5) ? ~scan_g & asid_eq & va_hit :
                 (scan_g | asid_eq) & va_hit;
  always_comb begin
    iop_d   = accept ? inv_op : iop_q;
    asid_d  = accept ? (is_inv ? inv_asid : csr_asid) : asid_q;
    va_d    = accept ? (is_inv ? inv_va : csr_vppn) : va_q;
    idx_d   = accept ? csr_index : idx_q;
    fill_d  = accept ? op_type == 3'd3 : fill_q;
    ine_d   = accept & bad;
    cnt_d   = scanning ? cnt_q + 1'b1 : '0;
    state_d = (accept & ~bad) ? ((op_type == 3'd0) ? SRCH_REQ : (op_type == 3'd1) ? RD : is_inv ? INV_SCAN : WR) :
              (state_q == SRCH_REQ) ? SRCH_RSP :
              (scanning & ~last) ? INV_SCAN : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ine_q   <= 1'b0;
      fill_q  <= 1'b0;
      iop_q   <= '0;
      asid_q  <= '0;
      va_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ine_q   <= ine_d;
      fill_q  <= fill_d;
      iop_q   <= iop_d;
      asid_q  <= asid_d;
      va_q    <= va_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef TLBFILL_RANDOM_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign fill_idx = lfsr_q[TLBNUMSIZE-1:0];
  always_ff @(posedge clk) lfsr_q <= reset ? 8'h01 : lfsr_d;
`else
  logic [TLBNUMSIZE-1:0] ptr_q, ptr_d;
  assign ptr_d = (we & fill_q) ? ptr_q + 1'b1 : ptr_q;
  assign fill_idx = ptr_q;
  always_ff @(posedge clk) ptr_q <= reset ? '0 : ptr_d;
`endif
  assign op_ready   = state_q == IDLE;
  assign s_req      = state_q == SRCH_REQ;
  assign s_vppn     = va_q;
  assign s_asid     = asid_q;
  assign s1e        = state_q == SRCH_RSP;
  assign s1_index   = s1e ? s_index : '0;
  assign s1_ne      = s1e & ~s_found;
  assign re         = state_q == RD;
  assign r_index    = idx_q;
  assign we         = state_q == WR;
  assign w_index    = fill_q ? fill_idx : idx_q;
  assign scan_index = cnt_q;
  assign inv_index  = cnt_q;
  assign inv_we     = scanning & scan_e & match;
  assign refetch    = re | we | (scanning & last);
  assign done       = refetch | s1e;
  assign ine_exc    = ine_q;
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: directed table-driven bench for tlb_op_ctrl (default build, round-robin fill)
module tb_tlb_op_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic op_valid = 1'b0, op_ready;
  logic [2:0] op_type = '0;
  logic [4:0] inv_op = '0;
  logic [9:0] inv_asid = '0, csr_asid = '0, s_asid, scan_asid;
  logic [18:0] inv_va = '0, csr_vppn = '0, s_vppn, scan_vppn;
  logic [3:0] csr_index = '0, s_index = '0, s1_index, r_index, w_index, scan_index, inv_index;
  logic s_req, s_found = 1'b0, s1e, s1_ne, re, we, scan_e, scan_g, inv_we, done, refetch, ine_exc;
  logic [5:0] scan_ps;
  logic e_m [16];
  logic g_m [16];
  logic [5:0] ps_m [16];
  logic [9:0] asid_m [16];
  logic [18:0] vppn_m [16];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign scan_e = e_m[scan_index];
  assign scan_g = g_m[scan_index];
  assign scan_ps = ps_m[scan_index];
  assign scan_asid = asid_m[scan_index];
  assign scan_vppn = vppn_m[scan_index];
  tlb_op_ctrl #(.TLBNUM(16), .TLBNUMSIZE(4)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va), .csr_index(csr_index),
    .csr_asid(csr_asid), .csr_vppn(csr_vppn), .s_req(s_req), .s_vppn(s_vppn), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .s1e(s1e), .s1_index(s1_index), .s1_ne(s1_ne),
    .re(re), .r_index(r_index), .we(we), .w_index(w_index), .scan_index(scan_index),
    .scan_e(scan_e), .scan_g(scan_g), .scan_ps(scan_ps), .scan_asid(scan_asid),
    .scan_vppn(scan_vppn), .inv_we(inv_we), .inv_index(inv_index), .done(done),
    .refetch(refetch), .ine_exc(ine_exc)
  );
  typedef struct {
    string name;
    logic [2:0] op;
    logic [4:0] iop;
    logic [3:0] idx;
    logic [7:0] strb;
    logic [3:0] oidx;
  } vec_t;
  typedef struct {
    string name;
    logic [4:0] iop;
    logic [15:0] mask;
  } inv_t;
  vec_t vecs [11];
  inv_t invs [7];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic issue(input logic [2:0] t, input logic [4:0] io, input logic [3:0] ix);
    op_type = t;
    inv_op = io;
    csr_index = ix;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
  endtask
  function automatic logic [7:0] strobes();
    return {s_req, s1e, re, we, inv_we, done, refetch, ine_exc};
  endfunction
  initial begin
    logic [15:0] mask;
    int done_at, dcnt;
    logic rf;
    vecs[0]  = '{"wr3",    3'd2, 5'd0,  4'd3,  8'h16, 4'd3};
    vecs[1]  = '{"rd3",    3'd1, 5'd0,  4'd3,  8'h26, 4'd3};
    vecs[2]  = '{"wr15",   3'd2, 5'd0,  4'd15, 8'h16, 4'd15};
    vecs[3]  = '{"rd9",    3'd1, 5'd0,  4'd9,  8'h26, 4'd9};
    vecs[4]  = '{"fill0",  3'd3, 5'd0,  4'd9,  8'h16, 4'd0};
    vecs[5]  = '{"fill1",  3'd3, 5'd0,  4'd9,  8'h16, 4'd1};
    vecs[6]  = '{"fill2",  3'd3, 5'd0,  4'd9,  8'h16, 4'd2};
    vecs[7]  = '{"fill3",  3'd3, 5'd0,  4'd9,  8'h16, 4'd3};
    vecs[8]  = '{"rsv5",   3'd5, 5'd0,  4'd1,  8'h01, 4'd0};
    vecs[9]  = '{"inv7",   3'd4, 5'd7,  4'd1,  8'h01, 4'd0};
    vecs[10] = '{"inv31",  3'd4, 5'd31, 4'd1,  8'h01, 4'd0};
    invs[0] = '{"inv_op0", 5'd0, 16'h3234};
    invs[1] = '{"inv_op1", 5'd1, 16'h3234};
    invs[2] = '{"inv_op2", 5'd2, 16'h3200};
    invs[3] = '{"inv_op3", 5'd3, 16'h0034};
    invs[4] = '{"inv_op4", 5'd4, 16'h0014};
    invs[5] = '{"inv_op5", 5'd5, 16'h0004};
    invs[6] = '{"inv_op6", 5'd6, 16'h1204};
    for (int i = 0; i < 16; i++) begin
      e_m[i] = 1'b0; g_m[i] = 1'b0; ps_m[i] = 6'd12; asid_m[i] = '0; vppn_m[i] = '0;
    end
    e_m[2] = 1'b1;  asid_m[2] = 10'd5; vppn_m[2] = 19'h123;
    e_m[4] = 1'b1;  asid_m[4] = 10'd5; vppn_m[4] = 19'h124;
    e_m[5] = 1'b1;  asid_m[5] = 10'd6; vppn_m[5] = 19'h123;
    asid_m[6] = 10'd5; vppn_m[6] = 19'h123;
    e_m[9] = 1'b1;  g_m[9] = 1'b1;  asid_m[9] = 10'd5; vppn_m[9] = 19'h123;
    e_m[12] = 1'b1; g_m[12] = 1'b1; ps_m[12] = 6'd21; vppn_m[12] = 19'h13C;
    e_m[13] = 1'b1; g_m[13] = 1'b1; vppn_m[13] = 19'h122;
    repeat (2) @(negedge clk);
    check("reset_ready", op_ready, 1);
    check("reset_strobes", strobes(), 0);
    check("reset_idx", {r_index, w_index, scan_index, inv_index, s1_index}, 0);
    reset = 1'b0;
    @(negedge clk);
    for (int v = 0; v < 11; v++) begin
      check({vecs[v].name, "_ready_in"}, op_ready, 1);
      issue(vecs[v].op, vecs[v].iop, vecs[v].idx);
      check({vecs[v].name, "_strobes"}, strobes(), vecs[v].strb);
      check({vecs[v].name, "_ready"}, op_ready, vecs[v].strb == 8'h01);
      if (vecs[v].strb[5] | vecs[v].strb[4])
        check({vecs[v].name, "_index"}, vecs[v].strb[5] ? r_index : w_index, vecs[v].oidx);
      @(negedge clk);
      check({vecs[v].name, "_quiet"}, {op_ready, strobes()}, 9'h100);
    end
    for (int i = 4; i < 16; i++) begin
      issue(3'd3, 5'd0, 4'd0);
      check("fill_seq", {we, w_index}, {1'b1, 4'(i)});
      @(negedge clk);
    end
    issue(3'd3, 5'd0, 4'd0);
    check("fill_wrap", {we, w_index}, 5'h10);
    @(negedge clk);
    csr_vppn = 19'h00123; csr_asid = 10'h005; s_found = 1'b1; s_index = 4'd7;
    issue(3'd0, 5'd0, 4'd0);
    csr_vppn = 19'h7FFFF; csr_asid = 10'h3FF;
    check("srch_req", strobes(), 8'h80);
    check("srch_key", {s_vppn, s_asid}, {19'h00123, 10'h005});
    @(negedge clk);
    check("srch_rsp", {strobes(), s1_ne}, 9'h088);
    check("srch_s1_index", s1_index, 7);
    @(negedge clk);
    check("srch_quiet", {op_ready, strobes()}, 9'h100);
    s_found = 1'b0; s_index = 4'd12;
    issue(3'd0, 5'd0, 4'd0);
    @(negedge clk);
    check("srch_miss", {s1e, s1_ne, s1_index, done, refetch}, {2'b11, 4'd12, 2'b10});
    @(negedge clk);
    inv_asid = 10'h005; inv_va = 19'h00123;
    for (int k = 0; k < 7; k++) begin
      issue(3'd4, invs[k].iop, 4'd0);
      mask = '0; dcnt = 0; done_at = -1; rf = 1'b0;
      for (int c = 0; c < 16; c++) begin
        if (c == 0) check({invs[k].name, "_scan0"}, scan_index, 0);
        if (inv_we) mask[inv_index] = 1'b1;
        if (done) begin dcnt++; done_at = c; rf = refetch; end
        @(negedge clk);
      end
      check({invs[k].name, "_mask"}, mask, invs[k].mask);
      check({invs[k].name, "_done"}, {dcnt, done_at}, {32'd1, 32'd15});
      check({invs[k].name, "_refetch"}, rf, 1);
      check({invs[k].name, "_quiet"}, {op_ready, strobes()}, 9'h100);
    end
    issue(3'd4, 5'd0, 4'd0);
    for (int c = 0; c < 20; c++) begin
      if (scan_index == 4'd5) break;
      @(negedge clk);
    end
    check("rst_reach5", {scan_index, inv_we}, {4'd5, 1'b1});
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_inv", {op_ready, strobes()}, 9'h100);
    check("rst_scan_idx", scan_index, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_after", {op_ready, strobes()}, 9'h100);
    issue(3'd3, 5'd0, 4'd0);
    check("rst_fill_ptr", {we, w_index}, 5'h10);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
